// File: rtl/rtc_stamp_if.sv
// ---------------------------------------------------------------------------
// rtc_stamp_if
//   Bundles the request, RTC register and UART-side signals of the RTC
//   timestamp streamer. clk/rst stay plain ports on the modules.
//
//   Request side : trig, autoEn, tick, mode12h
//   RTC side     : secData, minData, hrsData, dateData, monData, dayData,
//                  yrData (BCD, dayData 1=SUN..7=SAT)
//   UART side    : busy, done in; txEn, data out
//   Status       : frameActive, frameDone, overrun
//
//   Modports
//     slave  - the streamer itself (consumes requests and RTC data, drives
//              the byte stream and status)
//     master - the environment (cmdCtrl/RTC/UART core, or a testbench)
// ---------------------------------------------------------------------------
interface rtc_stamp_if;
   logic       trig;
   logic       autoEn;
   logic       tick;
   logic       mode12h;
   logic [7:0] secData;
   logic [7:0] minData;
   logic [7:0] hrsData;
   logic [7:0] dateData;
   logic [7:0] monData;
   logic [7:0] dayData;
   logic [7:0] yrData;
   logic       busy;
   logic       done;
   logic       txEn;
   logic [7:0] data;
   logic       frameActive;
   logic       frameDone;
   logic       overrun;

   modport slave (
      input  trig, autoEn, tick, mode12h,
      input  secData, minData, hrsData, dateData, monData, dayData, yrData,
      input  busy, done,
      output txEn, data, frameActive, frameDone, overrun
   );

   modport master (
      output trig, autoEn, tick, mode12h,
      output secData, minData, hrsData, dateData, monData, dayData, yrData,
      output busy, done,
      input  txEn, data, frameActive, frameDone, overrun
   );
endinterface

// File: rtl/rtc_stamp_streamer.sv
// ---------------------------------------------------------------------------
// rtc_stamp_streamer
//   Captures a coherent snapshot of the BCD RTC registers and streams the
//   ASCII line "YY. MM. DD. (DOW) HH:MM:SS[ AM|PM] TZZ<EOL>" byte by byte
//   into a UART Tx core. Requests come from a trig rising edge or from the
//   1 Hz tick while autoEn is set; one extra request can be queued while a
//   line is in flight, further ones are dropped with an overrun pulse.
//
//   Parameters
//     TZ_STR   - 3 ASCII chars of timezone suffix, MSB char sent first
//     SHOW_DOW - 1: emit "(DOW) " field, 0: omit it
//     EOL_CRLF - 1: CR LF line ending, 0: LF only
//
//   Ports
//     clk  - system clock
//     rst  - synchronous active-high reset
//     bus  - rtc_stamp_if.slave (requests, RTC registers, UART handshake,
//            txEn/data byte stream, frameActive/frameDone/overrun status)
// ---------------------------------------------------------------------------
module rtc_stamp_streamer #(
   parameter logic [23:0] TZ_STR   = "KST",
   parameter bit          SHOW_DOW = 1'b1,
   parameter bit          EOL_CRLF = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   rtc_stamp_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_WAIT_IDLE
   } state_t;

   // Field start positions within the line. The date block is always 12
   // bytes; the optional DOW block shifts everything after it.
   localparam logic [5:0] DATE_END  = 6'd12;
   localparam logic [5:0] TIME_BASE = SHOW_DOW ? 6'd18 : 6'd12;
   localparam logic [5:0] AMPM_BASE = TIME_BASE + 6'd9;
   localparam logic [5:0] LAST_24H  = AMPM_BASE + 6'd3 + (EOL_CRLF ? 6'd1 : 6'd0);

   state_t     state_q, state_d;
   logic [5:0] idx_q, idx_d;
   logic       pending_q, pending_d;
   logic       trig_prev_q, trig_prev_d;
   logic       frame_done_q, frame_done_d;
   logic       overrun_q, overrun_d;

   // Snapshot of the RTC registers taken in LOAD; the line is built only
   // from these so mid-frame RTC updates cannot tear the output.
   logic [7:0] yr_q, yr_d;
   logic [7:0] mon_q, mon_d;
   logic [7:0] date_q, date_d;
   logic [7:0] day_q, day_d;
   logic [7:0] hr_q, hr_d;
   logic [7:0] min_q, min_d;
   logic [7:0] sec_q, sec_d;
   logic       pm_q, pm_d;
   logic       m12_q, m12_d;

   logic       req;
   logic [7:0] hr_conv;
   logic       pm_conv;
   logic [5:0] tz_base;
   logic [5:0] eol_base;
   logic [5:0] last_idx;
   logic [5:0] rel;
   logic [7:0] tx_byte;

   function automatic logic [7:0] dig(input logic [3:0] n);
      return 8'h30 + {4'h0, n};
   endfunction

   function automatic logic [23:0] dow_name(input logic [7:0] d);
      logic [23:0] s;
      case (d)
         8'd1:    s = "SUN";
         8'd2:    s = "MON";
         8'd3:    s = "TUE";
         8'd4:    s = "WED";
         8'd5:    s = "THU";
         8'd6:    s = "FRI";
         8'd7:    s = "SAT";
         default: s = "---";
      endcase
      return s;
   endfunction

   // A trig edge and a tick in the same cycle collapse into one request.
   assign req = (bus.trig & ~trig_prev_q) | (bus.autoEn & bus.tick);

   // 24h -> 12h conversion done in BCD on the live hour register; the result
   // is only stored during LOAD. Hours above 12 subtract 0x12 with a decimal
   // borrow when the units digit is below 2 (0x20 -> 0x08, 0x21 -> 0x09).
   always_comb begin
      hr_conv = bus.hrsData;
      pm_conv = 1'b0;
      if (bus.mode12h) begin
         if (bus.hrsData == 8'h00) begin
            hr_conv = 8'h12;
         end else if (bus.hrsData == 8'h12) begin
            pm_conv = 1'b1;
         end else if (bus.hrsData > 8'h12) begin
            pm_conv = 1'b1;
            if (bus.hrsData[3:0] >= 4'd2) begin
               hr_conv = bus.hrsData - 8'h12;
            end else begin
               hr_conv = bus.hrsData - 8'h18;
            end
         end
      end
   end

   // Line layout depends on the snapshotted 12h flag.
   always_comb begin
      tz_base  = AMPM_BASE + (m12_q ? 6'd3 : 6'd0);
      eol_base = tz_base + 6'd3;
      last_idx = LAST_24H + (m12_q ? 6'd3 : 6'd0);
   end

   // Byte selection for the current index.
   always_comb begin
      tx_byte = 8'h00;
      rel     = 6'd0;
      if (idx_q < DATE_END) begin
         case (idx_q)
            6'd0:    tx_byte = dig(yr_q[7:4]);
            6'd1:    tx_byte = dig(yr_q[3:0]);
            6'd4:    tx_byte = dig(mon_q[7:4]);
            6'd5:    tx_byte = dig(mon_q[3:0]);
            6'd8:    tx_byte = dig(date_q[7:4]);
            6'd9:    tx_byte = dig(date_q[3:0]);
            6'd2, 6'd6, 6'd10: tx_byte = ".";
            default: tx_byte = " ";
         endcase
      end else if (idx_q < TIME_BASE) begin
         // Only reachable when the DOW block is present.
         rel = idx_q - DATE_END;
         case (rel)
            6'd0:    tx_byte = "(";
            6'd1:    tx_byte = dow_name(day_q)[23:16];
            6'd2:    tx_byte = dow_name(day_q)[15:8];
            6'd3:    tx_byte = dow_name(day_q)[7:0];
            6'd4:    tx_byte = ")";
            default: tx_byte = " ";
         endcase
      end else if (idx_q < AMPM_BASE) begin
         rel = idx_q - TIME_BASE;
         case (rel)
            6'd0:       tx_byte = dig(hr_q[7:4]);
            6'd1:       tx_byte = dig(hr_q[3:0]);
            6'd3:       tx_byte = dig(min_q[7:4]);
            6'd4:       tx_byte = dig(min_q[3:0]);
            6'd6:       tx_byte = dig(sec_q[7:4]);
            6'd7:       tx_byte = dig(sec_q[3:0]);
            6'd2, 6'd5: tx_byte = ":";
            default:    tx_byte = " ";
         endcase
      end else if (idx_q < tz_base) begin
         rel = idx_q - AMPM_BASE;
         case (rel)
            6'd0:    tx_byte = pm_q ? "P" : "A";
            6'd1:    tx_byte = "M";
            default: tx_byte = " ";
         endcase
      end else if (idx_q < eol_base) begin
         rel = idx_q - tz_base;
         case (rel)
            6'd0:    tx_byte = TZ_STR[23:16];
            6'd1:    tx_byte = TZ_STR[15:8];
            default: tx_byte = TZ_STR[7:0];
         endcase
      end else begin
         tx_byte = (EOL_CRLF && (idx_q == eol_base)) ? 8'h0D : 8'h0A;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      pending_d    = pending_q;
      trig_prev_d  = bus.trig;
      frame_done_d = 1'b0;
      overrun_d    = 1'b0;
      yr_d         = yr_q;
      mon_d        = mon_q;
      date_d       = date_q;
      day_d        = day_q;
      hr_d         = hr_q;
      min_d        = min_q;
      sec_d        = sec_q;
      pm_d         = pm_q;
      m12_d        = m12_q;

      case (state_q)
         ST_IDLE: begin
            if ((req | pending_q) & ~bus.busy) begin
               state_d = ST_LOAD;
               // With both a queued and a fresh request, one starts now and
               // the other stays queued.
               pending_d = req & pending_q;
            end else if (req) begin
               if (pending_q) begin
                  overrun_d = 1'b1;
               end else begin
                  pending_d = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            yr_d    = bus.yrData;
            mon_d   = bus.monData;
            date_d  = bus.dateData;
            day_d   = bus.dayData;
            hr_d    = hr_conv;
            min_d   = bus.minData;
            sec_d   = bus.secData;
            pm_d    = pm_conv;
            m12_d   = bus.mode12h;
            idx_d   = 6'd0;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (bus.done) begin
               if (idx_q == last_idx) begin
                  state_d = ST_WAIT_IDLE;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         ST_WAIT_IDLE: begin
            if (~bus.busy) begin
               state_d      = ST_IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Requests arriving while a frame is in progress use the queue slot.
      if ((state_q != ST_IDLE) && req) begin
         if (pending_q) begin
            overrun_d = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= 6'd0;
         pending_q    <= 1'b0;
         trig_prev_q  <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         yr_q         <= 8'h00;
         mon_q        <= 8'h00;
         date_q       <= 8'h00;
         day_q        <= 8'h00;
         hr_q         <= 8'h00;
         min_q        <= 8'h00;
         sec_q        <= 8'h00;
         pm_q         <= 1'b0;
         m12_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         trig_prev_q  <= trig_prev_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
         yr_q         <= yr_d;
         mon_q        <= mon_d;
         date_q       <= date_d;
         day_q        <= day_d;
         hr_q         <= hr_d;
         min_q        <= min_d;
         sec_q        <= sec_d;
         pm_q         <= pm_d;
         m12_q        <= m12_d;
      end
   end

   assign bus.txEn        = (state_q == ST_SEND);
   assign bus.data        = (state_q == ST_SEND) ? tx_byte : 8'h00;
   assign bus.frameActive = (state_q != ST_IDLE);
   assign bus.frameDone   = frame_done_q;
   assign bus.overrun     = overrun_q;

endmodule
